// File: rtl/lsu_sram_if.sv
// Core-side request/response handshake bundle for lsu_sram.
// master = core memory stage, slave = lsu_sram.
interface lsu_sram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_sram.sv
// Load/store front end for the 32-bit synchronous SRAM:
// lane steering, error checks and a buffered response.
module lsu_sram #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_sram_if.slave   bus,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RESP
  } state_t;

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        err;
  logic        accept;
  logic [3:0]  we_lane;
  logic [31:0] din;
  logic [31:0] lane;
  logic [31:0] ld_val;

  assign is_b = bus.req_size == 2'b00;
  assign is_h = bus.req_size == 2'b01;
  assign is_w = bus.req_size == 2'b10;

  assign err = (bus.req_size == 2'b11)
             | (is_h & bus.req_addr[0])
             | (is_w & (|bus.req_addr[1:0]))
             | (bus.req_addr >= LIMIT);

  assign bus.req_ready = rst_n &
    ((state == IDLE) |
     ((state == RESP) & bus.rsp_ready));

  assign accept = bus.req_valid & bus.req_ready;

  always_comb begin
    we_lane = 4'b1111;
    din     = bus.req_wdata;
    unique case (1'b1)
      is_b: begin
        we_lane = 4'b0001 << bus.req_addr[1:0];
        din     = {4{bus.req_wdata[7:0]}};
      end
      is_h: begin
        we_lane = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        din     = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Erroneous requests never reach the macro.
  assign mem_en  = accept & ~err;
  assign mem_we  = (mem_en & bus.req_we) ? we_lane : 4'b0000;
  assign mem_adr = bus.req_addr;
  assign mem_din = din;

  assign lane = mem_dout >> {ld_off, 3'b000};

  always_comb begin
    ld_val = mem_dout;
    unique case (1'b1)
      ld_size == 2'b00:
        ld_val = ld_uns ? {24'h0, lane[7:0]}
                        : {{24{lane[7]}}, lane[7:0]};
      ld_size == 2'b01:
        ld_val = ld_uns ? {16'h0, lane[15:0]}
                        : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ld_off    <= '0;
      ld_size   <= '0;
      ld_uns    <= 1'b0;
    end else if (accept) begin
      if (!bus.req_we && !err) begin
        state     <= LOAD;
        rsp_valid <= 1'b0;
        ld_off    <= bus.req_addr[1:0];
        ld_size   <= bus.req_size;
        ld_uns    <= bus.req_unsigned;
      end else begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= err;
      end
    end else begin
      unique case (state)
        LOAD: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_val;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_lsu_sram.sv
// Directed bench for lsu_sram with an SRAM model,
// a byte-level reference memory and a response scoreboard.
module tb_lsu_sram;
  localparam int unsigned MEM_BYTES = 65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_sram_if bus ();

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  lsu_sram #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  logic [31:0] sram [0:16383];
  logic [13:0] ra;
  always @(posedge clk) begin
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b])
          sram[mem_adr[15:2]][8*b +: 8] <= mem_din[8*b +: 8];
    ra <= mem_adr[15:2];
  end
  assign mem_dout = sram[ra];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] refm [0:65535];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int nassert = 0;
  int nfail = 0;
  int nresp = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic calc_err(input logic [1:0] sz,
                                    input logic [31:0] a);
    return (sz == 2'b11) ||
           (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) ||
           (a >= MEM_BYTES);
  endfunction

  function automatic logic [3:0] exp_we(input logic [1:0] sz,
                                        input logic [31:0] a);
    case (sz)
      2'b00: return 4'b0001 << a[1:0];
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [1:0] sz,
                                           input logic uns,
                                           input logic [31:0] a);
    logic [15:0] i;
    logic [15:0] h;
    i = a[15:0];
    h = {refm[i+16'd1], refm[i]};
    case (sz)
      2'b00: return uns ? {24'h0, refm[i]}
                        : {{24{refm[i][7]}}, refm[i]};
      2'b01: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {refm[i+16'd3], refm[i+16'd2],
                       refm[i+16'd1], refm[i]};
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz,
                           input logic [31:0] a,
                           input logic [31:0] wd);
    logic [15:0] i;
    i = a[15:0];
    refm[i] = wd[7:0];
    if (sz != 2'b00) refm[i+16'd1] = wd[15:8];
    if (sz == 2'b10) begin
      refm[i+16'd2] = wd[23:16];
      refm[i+16'd3] = wd[31:24];
    end
  endtask

  // Predict the response and record it in the scoreboard.
  task automatic predict(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
    logic e;
    e = calc_err(sz, a);
    if (e) sb.push_back('{32'h0, 1'b1});
    else if (we) begin
      ref_store(sz, a, wd);
      sb.push_back('{32'h0, 1'b0});
    end else sb.push_back('{load_val(sz, uns, a), 1'b0});
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output int acc);
    logic ok;
    logic e;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.req_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    e = calc_err(sz, a);
    chk("mem_en", 32'(mem_en), 32'(!e));
    if (we && !e) chk("mem_we", 32'(mem_we), 32'(exp_we(sz, a)));
    else chk("mem_we_off", 32'(mem_we), 32'd0);
    acc = cyc;
    predict(we, sz, uns, a, wd);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int acc, input int lat);
    logic ok;
    exp_t ex;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1)
        ok = 1'b1;
      else @(negedge clk);
    end
    chk("rsp_timeout", 32'(ok), 32'd1);
    if (ok) begin
      if (lat >= 0) chk("rsp_latency", 32'(cyc - acc), 32'(lat));
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        ex = sb.pop_front();
        nresp++;
        chk("rsp_rdata", bus.rsp_rdata, ex.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(ex.err));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    exp_t ex;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b1;

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, acc);
    get_rsp(acc, 2);

    // Byte and half lanes
    issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h11, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h22, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h202, 32'h33, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h80, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h204, 32'h01234567, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h206, 32'hFFFFA5B6, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, acc);
    get_rsp(acc, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h206, 32'h0, acc);
    get_rsp(acc, 2);

    // Error cases
    issue(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h55555555, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b10, 1'b0, MEM_BYTES, 32'h0, acc);
    get_rsp(acc, 1);
    issue(1'b1, 2'b00, 1'b0, MEM_BYTES + 32'd1, 32'h77, acc);
    get_rsp(acc, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, acc);
    get_rsp(acc, 2);

    // Response backpressure
    bus.rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, acc);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = (i % 2 == 0) ? 32'h300 : 32'h304;
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_mem_en", 32'(mem_en), 32'd0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    get_rsp(acc, -1);

    // Back-to-back stores
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h400 + 32'(4 * i);
      bus.req_wdata = 32'hA0000000 + 32'(i * 17);
      #1;
      chk("b2b_ready", 32'(bus.req_ready), 32'd1);
      chk("b2b_mem_en", 32'(mem_en), 32'd1);
      chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(i > 0));
      if (bus.rsp_valid === 1'b1 && sb.size() > 0) begin
        ex = sb.pop_front();
        nresp++;
        chk("b2b_rdata", bus.rsp_rdata, ex.rdata);
        chk("b2b_err", 32'(bus.rsp_err), 32'(ex.err));
      end
      predict(1'b1, 2'b10, 1'b0, bus.req_addr, bus.req_wdata);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    get_rsp(acc, -1);
    chk("b2b_count", 32'(nresp), 32'd10);
    issue(1'b0, 2'b10, 1'b0, 32'h40C, 32'h0, acc);
    get_rsp(acc, 2);

    // Reset during LOAD drops the transaction
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, acc);
    rst_n = 1'b0;
    #1;
    chk("rl_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("rl_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    if (sb.size() > 0) ex = sb.pop_front();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rl_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    #1;
    chk("rl_idle", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, acc);
    get_rsp(acc, 2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end
endmodule
